// File: rtl/sprite_animator.sv
// Animated sprite overlay for a VGA scan: windowed fetch from a frame-packed
// RGB565 sprite memory, optional 2x replication, RGB444 output one cycle later.
module sprite_animator #(
    parameter int          H_VALID  = 640,
    parameter int          V_VALID  = 480,
    parameter int          PIC_W    = 64,
    parameter int          PIC_H    = 48,
    parameter int          N_FRAMES = 4,
    parameter int          HOLD     = 8,
    parameter int          ADDR_W   = 18,
    parameter logic [11:0] BG_COLOR = 12'h000,
    localparam int         FI_W     = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              scale2,
    input  logic              anim_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [15:0]       mem_rdata,
    output logic [11:0]       data_out,
    output logic [FI_W-1:0]   frame_idx,
    output logic              frame_end
);

    localparam int                HOLD_W   = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(PIC_W * PIC_H);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(PIC_W);

    logic [9:0]        sx_q, sy_q;
    logic              s2_q;
    logic              frame_end_q, hit_q;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [FI_W-1:0]   fidx_q, fidx_d;
    logic [ADDR_W-1:0] fbase_q, fbase_d;
    logic [10:0]       col_q;
    logic [ADDR_W-1:0] lbase_q;
    logic              rsub_q;

    logic              frame_end_d;
    logic [10:0]       win_w_s, win_h_s;
    logic              x_in_s, y_in_s, hit_s, left_s, top_s;
    logic [10:0]       col_cur_s, col_term_s;
    logic [ADDR_W-1:0] lbase_cur_s;
    logic              rsub_cur_s;
    logic              unused_s;

    assign unused_s    = ^{mem_rdata[11], mem_rdata[6:5], mem_rdata[0]};
    assign frame_end_d = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));
    assign left_s      = (pix_x == sx_q);
    assign top_s       = (pix_y == sy_q);

    // Window hit test at 11 bits so a window running past 1023 never wraps
    always_comb begin
        win_w_s = 11'(PIC_W);
        win_h_s = 11'(PIC_H);
        if (s2_q) begin
            win_w_s = 11'(2 * PIC_W);
            win_h_s = 11'(2 * PIC_H);
        end else begin
            win_w_s = 11'(PIC_W);
            win_h_s = 11'(PIC_H);
        end
        x_in_s = ({1'b0, pix_x} >= {1'b0, sx_q}) &&
                 ({1'b0, pix_x} <  ({1'b0, sx_q} + win_w_s)) &&
                 ({1'b0, pix_x} <  11'(H_VALID));
        y_in_s = ({1'b0, pix_y} >= {1'b0, sy_q}) &&
                 ({1'b0, pix_y} <  ({1'b0, sy_q} + win_h_s)) &&
                 ({1'b0, pix_y} <  11'(V_VALID));
        hit_s  = x_in_s && y_in_s && rst;
    end

    // Row base steps by one sprite line at each window left edge (every other line in 2x)
    always_comb begin
        col_cur_s   = col_q;
        lbase_cur_s = lbase_q;
        rsub_cur_s  = rsub_q;
        if (left_s) begin
            col_cur_s = 11'd0;
            if (top_s) begin
                lbase_cur_s = {ADDR_W{1'b0}};
                rsub_cur_s  = 1'b0;
            end else if (!s2_q || rsub_q) begin
                lbase_cur_s = lbase_q + ROW_STEP;
                rsub_cur_s  = 1'b0;
            end else begin
                lbase_cur_s = lbase_q;
                rsub_cur_s  = 1'b1;
            end
        end else begin
            col_cur_s = col_q;
        end
        if (s2_q) begin
            col_term_s = {1'b0, col_cur_s[10:1]};
        end else begin
            col_term_s = col_cur_s;
        end
    end

    assign mem_en   = hit_s;
    assign mem_addr = fbase_q + lbase_cur_s + ADDR_W'(col_term_s);

    // Animation next state: hold counter and frame index move only on frame_end
    always_comb begin
        hold_d  = hold_q;
        fidx_d  = fidx_q;
        fbase_d = fbase_q;
        if (frame_end_q && anim_en) begin
            if (hold_q == HOLD_W'(HOLD - 1)) begin
                hold_d = {HOLD_W{1'b0}};
                if (fidx_q == FI_W'(N_FRAMES - 1)) begin
                    fidx_d  = {FI_W{1'b0}};
                    fbase_d = {ADDR_W{1'b0}};
                end else begin
                    fidx_d  = fidx_q + FI_W'(1);
                    fbase_d = fbase_q + FRAME_SZ;
                end
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end else begin
            hold_d = hold_q;
        end
    end

    // Frame timing, shadow position/scale and animation state
    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            frame_end_q <= 1'b0;
            hit_q       <= 1'b0;
            sx_q        <= 10'd0;
            sy_q        <= 10'd0;
            s2_q        <= 1'b0;
            hold_q      <= {HOLD_W{1'b0}};
            fidx_q      <= {FI_W{1'b0}};
            fbase_q     <= {ADDR_W{1'b0}};
        end else begin
            frame_end_q <= frame_end_d;
            hit_q       <= hit_s;
            hold_q      <= hold_d;
            fidx_q      <= fidx_d;
            fbase_q     <= fbase_d;
            if (frame_end_q) begin
                sx_q <= pos_x;
                sy_q <= pos_y;
                s2_q <= scale2;
            end
        end
    end

    // Incremental column/line-base counters
    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            col_q   <= 11'd0;
            lbase_q <= {ADDR_W{1'b0}};
            rsub_q  <= 1'b0;
        end else if (frame_end_q) begin
            col_q   <= 11'd0;
            lbase_q <= {ADDR_W{1'b0}};
            rsub_q  <= 1'b0;
        end else if (hit_s) begin
            col_q   <= col_cur_s + 11'd1;
            lbase_q <= lbase_cur_s;
            rsub_q  <= rsub_cur_s;
        end
    end

    // RGB565 -> RGB444 on the pixel fetched last cycle
    always_comb begin
        if (hit_q) begin
            data_out = {mem_rdata[15:12], mem_rdata[10:7], mem_rdata[4:1]};
        end else begin
            data_out = BG_COLOR;
        end
    end

    assign frame_idx = fidx_q;
    assign frame_end = frame_end_q;

endmodule

// File: tb/tb_sprite_animator.sv
// Scoreboard bench for sprite_animator: formula-based model of window/address,
// table of probe points, and hand sequences for animation, freeze and reset.
module tb_sprite_animator;

    localparam int          H   = 640;
    localparam int          V   = 480;
    localparam int          W   = 64;
    localparam int          PH  = 48;
    localparam int          NF  = 4;
    localparam int          HLD = 8;
    localparam int          AW  = 18;
    localparam logic [11:0] BG  = 12'h000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [9:0]    pix_x = 10'd700, pix_y = 10'd500, pos_x = 10'd0, pos_y = 10'd0;
    logic          scale2 = 1'b0, anim_en = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_en;
    logic [15:0]   mem_rdata = 16'h0000;
    logic [11:0]   data_out;
    logic [1:0]    frame_idx;
    logic          frame_end;

    sprite_animator dut (
        .vga_clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y),
        .pos_x(pos_x), .pos_y(pos_y), .scale2(scale2), .anim_en(anim_en),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_rdata(mem_rdata),
        .data_out(data_out), .frame_idx(frame_idx), .frame_end(frame_end)
    );

    always #5 clk = ~clk;

    typedef struct { logic [11:0] data; logic fe; } exp_t;
    typedef struct { int scen; int x; int y; bit en; int addr; } probe_t;
    typedef struct { int px; int py; bit sc; } scen_t;

    exp_t   sb_q[$];
    probe_t probes[19];
    scen_t  scens[3];
    int     n_chk = 0, n_fail = 0;
    int     cur_scen = -1;
    int     m_sx = 0, m_sy = 0, m_fidx = 0, m_hold = 0, m_prev_addr = 0;
    bit     m_s2 = 0, m_fe = 0, m_prev_hit = 0;

    function automatic logic [15:0] mem_model(input int a);
        logic [31:0] t;
        t = 32'(a) * 32'd40503 + 32'd4660;
        if (a == 0) return 16'hF800;
        return t[15:0];
    endfunction

    function automatic logic [11:0] conv(input logic [15:0] d);
        return {d[15:12], d[10:7], d[4:1]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at pix (%0d,%0d): got %0h, expected %0h", nm, pix_x, pix_y, act, exp);
        end
    endtask

    task automatic calc(input int x, input int y, output bit h, output int a);
        int s;
        s = m_s2 ? 2 : 1;
        h = (x >= m_sx) && (x < m_sx + W * s) && (y >= m_sy) && (y < m_sy + PH * s) &&
            (x < H) && (y < V);
        a = m_fidx * W * PH + ((y - m_sy) / s) * W + (x - m_sx) / s;
    endtask

    task automatic model_edge();
        if (m_fe) begin
            m_sx = int'(pos_x);
            m_sy = int'(pos_y);
            m_s2 = scale2;
            if (anim_en) begin
                if (m_hold == HLD - 1) begin
                    m_hold = 0;
                    m_fidx = (m_fidx + 1) % NF;
                end else begin
                    m_hold++;
                end
            end
        end
        m_fe = (int'(pix_x) == H - 1) && (int'(pix_y) == V - 1);
    endtask

    task automatic push_exp(input int x, input int y, input bit h, input int a);
        exp_t e;
        e.data = h ? conv(mem_model(a)) : BG;
        e.fe   = (x == H - 1) && (y == V - 1);
        sb_q.push_back(e);
        m_prev_hit  = h;
        m_prev_addr = a;
    endtask

    task automatic pix(input int x, input int y);
        bit   h;
        int   a;
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        pix_x     = 10'(x);
        pix_y     = 10'(y);
        mem_rdata = m_prev_hit ? mem_model(m_prev_addr) : 16'hDEAD;
        calc(x, y, h, a);
        @(negedge clk);
        check("mem_en", 32'(mem_en), 32'(h));
        if (h) check("mem_addr", 32'(mem_addr), 32'(a));
        check("frame_idx", 32'(frame_idx), 32'(m_fidx));
        if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_empty at pix (%0d,%0d)", x, y);
        end else begin
            e = sb_q.pop_front();
            check("data_out", 32'(data_out), 32'(e.data));
            check("frame_end", 32'(frame_end), 32'(e.fe));
        end
        for (int i = 0; i < 19; i++) begin
            if (probes[i].scen == cur_scen && probes[i].x == x && probes[i].y == y) begin
                check("probe_en", 32'(mem_en), 32'(probes[i].en));
                if (probes[i].en) check("probe_addr", 32'(mem_addr), 32'(probes[i].addr));
            end
        end
        push_exp(x, y, h, a);
    endtask

    task automatic end_frame();
        pix(H - 1, V - 1);
        pix(H, V - 1);
        pix(H, V);
    endtask

    task automatic do_reset();
        bit h;
        int a;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_data_out", 32'(data_out), 32'(BG));
        check("rst_frame_idx", 32'(frame_idx), 32'd0);
        check("rst_frame_end", 32'(frame_end), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hold_mem_en", 32'(mem_en), 32'd0);
        check("rst_hold_data_out", 32'(data_out), 32'(BG));
        rst = 1'b1;
        m_sx = 0; m_sy = 0; m_s2 = 0; m_fidx = 0; m_hold = 0; m_fe = 0;
        sb_q.delete();
        calc(int'(pix_x), int'(pix_y), h, a);
        push_exp(int'(pix_x), int'(pix_y), h, a);
    endtask

    initial begin
        int s, x0, xe, ye;
        scens[0] = '{100, 50, 1'b0};
        scens[1] = '{0, 0, 1'b1};
        scens[2] = '{600, 450, 1'b0};
        probes[0]  = '{0, 100, 50, 1'b1, 0};
        probes[1]  = '{0, 163, 97, 1'b1, 3071};
        probes[2]  = '{0, 164, 97, 1'b0, 0};
        probes[3]  = '{0, 100, 98, 1'b0, 0};
        probes[4]  = '{0, 99, 50, 1'b0, 0};
        probes[5]  = '{1, 0, 0, 1'b1, 0};
        probes[6]  = '{1, 1, 0, 1'b1, 0};
        probes[7]  = '{1, 0, 1, 1'b1, 0};
        probes[8]  = '{1, 1, 1, 1'b1, 0};
        probes[9]  = '{1, 2, 0, 1'b1, 1};
        probes[10] = '{1, 0, 2, 1'b1, 64};
        probes[11] = '{1, 128, 0, 1'b0, 0};
        probes[12] = '{1, 127, 95, 1'b1, 3071};
        probes[13] = '{1, 0, 96, 1'b0, 0};
        probes[14] = '{2, 600, 450, 1'b1, 0};
        probes[15] = '{2, 639, 450, 1'b1, 39};
        probes[16] = '{2, 640, 450, 1'b0, 0};
        probes[17] = '{2, 639, 479, 1'b1, 1895};
        probes[18] = '{2, 600, 480, 1'b0, 0};

        do_reset();
        pix(700, 500);

        // Window scans: position loads at frame_end, then inputs are scrambled mid-frame
        for (int i = 0; i < 3; i++) begin
            cur_scen = -1;
            pos_x  = 10'(scens[i].px);
            pos_y  = 10'(scens[i].py);
            scale2 = scens[i].sc;
            end_frame();
            pos_x  = 10'd3;
            pos_y  = 10'd7;
            scale2 = ~scens[i].sc;
            cur_scen = i;
            s  = scens[i].sc ? 2 : 1;
            x0 = (scens[i].px > 0) ? scens[i].px - 1 : 0;
            xe = scens[i].px + W * s;
            ye = scens[i].py + PH * s;
            for (int y = scens[i].py; y <= ye; y++)
                for (int x = x0; x <= xe; x++)
                    pix(x, y);
        end

        // Animation: 8 frame_end pulses per animation frame, wrap after 4
        cur_scen = -1;
        pos_x = 10'd100; pos_y = 10'd50; scale2 = 1'b0; anim_en = 1'b0;
        end_frame();
        anim_en = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            end_frame();
            check("anim_seq_idx", 32'(frame_idx), 32'((k / 8) % 4));
            pix(100, 50);
            if (k == 8) check("frame1_first_addr", 32'(mem_addr), 32'd3072);
        end

        // Freeze at hold=5, then resume
        for (int k = 0; k < 5; k++) end_frame();
        anim_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            end_frame();
            check("frozen_idx", 32'(frame_idx), 32'd0);
        end
        anim_en = 1'b1;
        end_frame();
        check("resume_hold6_idx", 32'(frame_idx), 32'd0);
        end_frame();
        check("resume_hold7_idx", 32'(frame_idx), 32'd0);
        end_frame();
        check("resume_advance_idx", 32'(frame_idx), 32'd1);

        // Reset in the middle of the sprite
        for (int y = 50; y <= 60; y++)
            for (int x = 99; x <= 164; x++)
                pix(x, y);
        for (int x = 99; x <= 120; x++) pix(x, 61);
        do_reset();
        for (int x = 121; x <= 164; x++) pix(x, 61);
        for (int x = 0; x <= 70; x++) pix(x, 62);
        end_frame();
        pix(100, 50);
        check("post_rst_mem_en", 32'(mem_en), 32'd1);
        check("post_rst_addr", 32'(mem_addr), 32'd0);
        pix(101, 50);
        check("post_rst_data_F800", 32'(data_out), 32'h0F00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_animator.md
SPRITE_ANIMATOR -- requirements
Module: sprite_animator

Interface
REQ-001 SHALL have parameter H_VALID, default 640, active pixels per line.
REQ-002 SHALL have parameter V_VALID, default 480, active lines per frame.
REQ-003 SHALL have parameter PIC_W, default 64, sprite width in pixels.
REQ-004 SHALL have parameter PIC_H, default 48, sprite height in lines.
REQ-005 SHALL have parameter N_FRAMES, default 4, animation frames stored back-to-back in memory.
REQ-006 SHALL have parameter HOLD, default 8, displayed video frames per animation frame (>=1).
REQ-007 SHALL have parameter ADDR_W, default 18, memory address width; N_FRAMES*PIC_W*PIC_H <= 2^ADDR_W.
REQ-008 SHALL have parameter BG_COLOR, default 12'h000, RGB444 colour outside the sprite.
REQ-009 SHALL have port vga_clk, input, 1, sole clock; all state on rising edge.
REQ-010 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-011 SHALL have ports pix_x, pix_y, input, 10 each, current scan position; values >= H_VALID/V_VALID are blanking.
REQ-012 SHALL have ports pos_x, pos_y, input, 10 each, requested sprite top-left corner.
REQ-013 SHALL have port scale2, input, 1, 0 = 1x, 1 = 2x pixel replication.
REQ-014 SHALL have port anim_en, input, 1, 1 = advance frames, 0 = freeze on current frame.
REQ-015 SHALL have port mem_addr, output, ADDR_W, sprite memory read address.
REQ-016 SHALL have port mem_en, output, 1, memory read enable.
REQ-017 SHALL have port mem_rdata, input, 16, RGB565 data, valid exactly 1 cycle after mem_en.
REQ-018 SHALL have port data_out, output, 12, RGB444 pixel.
REQ-019 SHALL have port frame_idx, output, clog2(N_FRAMES) (min 1), animation frame displayed.
REQ-020 SHALL have port frame_end, output, 1, one-cycle pulse at end of active frame.

Function
REQ-021 SHALL register pos_x, pos_y, scale2 into shadow registers only on the cycle frame_end is asserted; the window uses shadow values only (no tearing).
REQ-022 SHALL assert frame_end for one cycle, in the cycle after pix_x==H_VALID-1 and pix_y==V_VALID-1 are presented.
REQ-023 SHALL define S=2 if shadow scale2 else 1; hit = pix_x in [sx, sx+PIC_W*S) and pix_y in [sy, sy+PIC_H*S) and pix_x<H_VALID and pix_y<V_VALID, compared at 11 bits (no wrap past 1023).
REQ-024 SHALL drive mem_en = hit combinationally, same cycle as pix_x/pix_y.
REQ-025 SHALL drive mem_addr, when hit, = frame_idx*PIC_W*PIC_H + ((pix_y-sy)/S)*PIC_W + (pix_x-sx)/S; don't-care when not hit.
REQ-026 SHALL compute the row/column terms incrementally (column counter and line-base register, reset at window left edge and frame_end); no per-pixel multiplier.
REQ-027 SHALL register hit into hit_d; data_out = {mem_rdata[15:12], mem_rdata[10:7], mem_rdata[4:1]} when hit_d, else BG_COLOR: 1-cycle latency from pix_x/pix_y.
REQ-028 SHALL hold a hold counter 0..HOLD-1, incremented at each frame_end while anim_en=1; on reaching HOLD-1 it wraps to 0 and frame_idx advances.
REQ-029 SHALL wrap frame_idx from N_FRAMES-1 to 0.
REQ-030 SHALL, when anim_en=0, freeze both frame_idx and hold counter (values kept, not cleared).
REQ-031 SHALL apply a frame_idx change from frame_end onward, so a whole frame always shows one animation frame.
REQ-032 SHALL clip a sprite partly beyond H_VALID/V_VALID: off-screen pixels not fetched, on-screen pixels keep correct addresses.

Reset
REQ-033 SHALL on rst=0 asynchronously clear frame_idx, hold counter, hit_d, frame_end, counters, and shadow registers (sx=sy=0, S=1).
REQ-034 SHALL output data_out=BG_COLOR, mem_en=0 during reset and until the first hit after release.
REQ-035 SHALL on reset mid-frame start from frame 0 at the next scan position with no stale fetch.

Verification
REQ-036 pos=(100,50), scale2=0, scan frame -> mem_en first at (100,50) with addr 0; at (163,97) addr 3071; data_out for mem_rdata=16'hF800 is 12'hF00 one cycle later.
REQ-037 scale2=1, pos=(0,0) -> (0,0),(1,0),(0,1),(1,1) all addr 0; (2,0) addr 1; (0,2) addr 64; window ends at x=128, y=96.
REQ-038 anim_en=1, HOLD=8, N_FRAMES=4 -> frame_idx 0,1,2,3,0 after every 8 frame_end pulses; frame 1 first addr 3072.
REQ-039 pos change mid-frame -> window unchanged until after frame_end; anim_en=0 at hold=5 freezes, resuming advances after 2 more frames.
REQ-040 pos=(600,450) -> fetch only x 600..639, y 450..479; (639,450) addr 39; no mem_en at x>=640.
REQ-041 rst pulse mid-sprite -> data_out=BG_COLOR, mem_en=0, frame_idx=0 immediately, window at (0,0) 1x.
